// File: rtl/tone_period_meter.sv
// tone_period_meter: measures period, high time, duty class, silence and
// pitch stability of a pulse-width tone on a single asynchronous input.
//
// Output handshake: valid is a one-cycle strobe with no ready. period_out,
// high_out, duty_class and stable all change on the same edge that raises
// valid, and they hold until the next valid. silent and the cleared outputs
// change on their own when the tone times out, and valid stays low then.
module tone_period_meter #(
    parameter int PW         = 21,
    parameter int TIMEOUT    = 2_000_000,
    parameter int MIN_PERIOD = 1000,
    parameter int STABLE_N   = 4,
    parameter int TOL_SHIFT  = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sig_in,
    output logic [PW-1:0] period_out,
    output logic [PW-1:0] high_out,
    output logic [2:0]    duty_class,
    output logic          valid,
    output logic          silent,
    output logic          stable
);

    localparam int DW = PW + 5;
    localparam int MW = $clog2(STABLE_N + 1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MEASURE = 1'b1;

    localparam logic [PW-1:0] TIMEOUT_C  = PW'(TIMEOUT);
    localparam logic [PW-1:0] MIN_C      = PW'(MIN_PERIOD);
    localparam logic [MW-1:0] STABLE_C   = MW'(STABLE_N);

    logic [0:0]    state;
    logic          sync1;
    logic          sig_s;
    logic          prev_s;
    logic [PW-1:0] cnt;
    logic [PW-1:0] hcnt;
    logic [PW-1:0] prev_period;
    logic [MW-1:0] match_cnt;

    logic          rise;
    logic          at_timeout;
    logic          long_enough;
    logic          restart;
    logic          accept;
    logic [DW-1:0] h32;
    logic [DW-1:0] p_ext;
    logic [DW-1:0] p3;
    logic [DW-1:0] p6;
    logic [DW-1:0] p12;
    logic [2:0]    duty_next;
    logic [PW-1:0] diff;
    logic [PW-1:0] tol;
    logic [MW-1:0] match_next;

    // Two-flop synchroniser for the asynchronous tone, plus one delay stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sig_s  <= 1'b0;
            prev_s <= 1'b0;
        end else begin
            sync1  <= sig_in;
            sig_s  <= sync1;
            prev_s <= sig_s;
        end
    end

    // Rise qualification: a rise in IDLE always restarts; in MEASURE only far enough from the reference
    always_comb begin
        rise        = sig_s & ~prev_s;
        at_timeout  = (cnt == TIMEOUT_C);
        long_enough = (cnt >= MIN_C);
        restart     = rise & ((state == IDLE) | long_enough);
        accept      = rise & (state == MEASURE) & long_enough;
    end

    // Period and high-time counters; glitch rises leave them running untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            hcnt <= '0;
        end else if (restart) begin
            cnt  <= PW'(1);
            hcnt <= PW'(1);
        end else begin
            if (!at_timeout) begin
                cnt <= cnt + 1'b1;
            end
            if (sig_s && (hcnt != TIMEOUT_C)) begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    // Duty class from H*32 against P*3/6/12, built from shifts and adds only
    always_comb begin
        h32   = {hcnt, 5'b00000};
        p_ext = DW'(cnt);
        p3    = (p_ext << 1) + p_ext;
        p6    = p3 << 1;
        p12   = p3 << 2;
        if (h32 < p3) begin
            duty_next = 3'd1;
        end else if (h32 < p6) begin
            duty_next = 3'd2;
        end else if (h32 < p12) begin
            duty_next = 3'd3;
        end else begin
            duty_next = 3'd4;
        end
    end

    // Stability run length: match_cnt==0 marks the first accept since IDLE
    always_comb begin
        diff = (cnt >= prev_period) ? (cnt - prev_period) : (prev_period - cnt);
        tol  = prev_period >> TOL_SHIFT;
        if (match_cnt == '0) begin
            match_next = MW'(1);
        end else if (diff <= tol) begin
            match_next = (match_cnt == STABLE_C) ? STABLE_C : (match_cnt + 1'b1);
        end else begin
            match_next = MW'(1);
        end
    end

    // Measurement FSM: publishes accepted measurements and declares silence on timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            period_out  <= '0;
            high_out    <= '0;
            duty_class  <= 3'd0;
            valid       <= 1'b0;
            silent      <= 1'b1;
            stable      <= 1'b0;
            match_cnt   <= '0;
            prev_period <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (accept) begin
                        period_out  <= cnt;
                        high_out    <= hcnt;
                        duty_class  <= duty_next;
                        valid       <= 1'b1;
                        silent      <= 1'b0;
                        match_cnt   <= match_next;
                        stable      <= (match_next == STABLE_C);
                        prev_period <= cnt;
                    end else if (!rise && at_timeout) begin
                        state      <= IDLE;
                        silent     <= 1'b1;
                        stable     <= 1'b0;
                        match_cnt  <= '0;
                        period_out <= '0;
                        high_out   <= '0;
                        duty_class <= 3'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_period_meter.sv
// tb_tone_period_meter: directed tone sequences with hand-computed
// period, high time, duty class, silence and stability expectations.
module tb_tone_period_meter;

    localparam int PW      = 21;
    localparam int TIMEOUT = 4000;

    logic          clk;
    logic          rst;
    logic          sig_in;
    logic [PW-1:0] period_out;
    logic [PW-1:0] high_out;
    logic [2:0]    duty_class;
    logic          valid;
    logic          silent;
    logic          stable;

    int n_vec;
    int n_err;
    int n_valid;
    int cyc;
    int last_valid_cyc;
    int n0;

    logic [PW-1:0] exp_q[$];

    tone_period_meter #(
        .PW(PW),
        .TIMEOUT(TIMEOUT),
        .MIN_PERIOD(1000),
        .STABLE_N(4),
        .TOL_SHIFT(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sig_in(sig_in),
        .period_out(period_out),
        .high_out(high_out),
        .duty_class(duty_class),
        .valid(valid),
        .silent(silent),
        .stable(stable)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock cycle with sig_in = v; every valid strobe is scored against exp_q
    task automatic step(input logic v);
        sig_in = v;
        @(posedge clk);
        #1;
        cyc++;
        if (valid) begin
            n_valid++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'd1, 32'd0);
            end else begin
                check("q_period", period_out, exp_q.pop_front());
            end
        end
    endtask

    // One tone period starting with a rise; exp_p is the period the strobe inside it reports (0: none)
    task automatic pulse(input int period, input int high, input int exp_p);
        if (exp_p != 0) exp_q.push_back(PW'(exp_p));
        for (int i = 0; i < period; i++) step(i < high);
    endtask

    task automatic expect_meas(input string tag, input int p, input int h, input int d, input int st);
        check({tag, "_period"}, period_out, p);
        check({tag, "_high"}, high_out, h);
        check({tag, "_duty"}, duty_class, d);
        check({tag, "_stable"}, stable, st);
        check({tag, "_silent"}, silent, 0);
    endtask

    task automatic expect_reset(input string tag);
        check({tag, "_period"}, period_out, 0);
        check({tag, "_high"}, high_out, 0);
        check({tag, "_duty"}, duty_class, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_silent"}, silent, 1);
        check({tag, "_stable"}, stable, 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        n_valid = 0;
        cyc = 0;
        last_valid_cyc = 0;
        rst = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_reset("reset");
        rst = 1'b0;
        repeat (3) step(1'b0);

        // Square wave 1000/250
        pulse(1000, 250, 0);
        check("sq_first_no_valid", n_valid, 0);
        check("sq_first_silent", silent, 1);
        for (int k = 2; k <= 6; k++) begin
            pulse(1000, 250, 1000);
            check("sq_count", n_valid, k - 1);
            expect_meas("sq", 1000, 250, 3, (k - 1 >= 4) ? 1 : 0);
        end

        // Duty sweep; each check reports the previous pulse's shape
        pulse(1000, 62, 1000);
        pulse(1000, 125, 1000);
        expect_meas("duty62", 1000, 62, 1, 1);
        pulse(1000, 500, 1000);
        expect_meas("duty125", 1000, 125, 2, 1);
        pulse(1000, 1, 1000);
        expect_meas("duty500", 1000, 500, 4, 1);
        pulse(1000, 250, 1000);
        expect_meas("duty_min", 1000, 1, 1, 1);

        // Glitch: 5-cycle pulse 300 cycles into the period
        n0 = n_valid;
        exp_q.push_back(PW'(1000));
        for (int i = 0; i < 1000; i++) step((i < 250) || (i >= 300 && i < 305));
        check("glitch_count", n_valid, n0 + 1);
        pulse(1000, 250, 1000);
        expect_meas("glitch", 1000, 255, 3, 1);

        // Silence: hold low until exactly TIMEOUT cycles after the last accept
        while (cyc < last_valid_cyc + TIMEOUT - 1) step(1'b0);
        check("pre_timeout_silent", silent, 0);
        check("pre_timeout_period", period_out, 1000);
        step(1'b0);
        check("timeout_silent", silent, 1);
        check("timeout_stable", stable, 0);
        check("timeout_period", period_out, 0);
        check("timeout_high", high_out, 0);
        check("timeout_duty", duty_class, 0);
        n0 = n_valid;
        pulse(1000, 250, 0);
        check("after_silence_first", n_valid, n0);
        check("after_silence_still_silent", silent, 1);
        pulse(1000, 250, 1000);
        check("after_silence_second", n_valid, n0 + 1);
        expect_meas("after_silence", 1000, 250, 3, 0);

        // Pitch change after stable
        pulse(1000, 250, 1000);
        pulse(1000, 250, 1000);
        pulse(1000, 250, 1000);
        check("pitch_stable_1000", stable, 1);
        pulse(1010, 250, 1000);
        pulse(1100, 250, 1010);
        expect_meas("pitch_1010", 1010, 250, 3, 1);
        pulse(1100, 250, 1100);
        expect_meas("pitch_1100_drop", 1100, 250, 3, 0);
        pulse(1100, 250, 1100);
        check("pitch_1100_m2", stable, 0);
        pulse(1100, 250, 1100);
        check("pitch_1100_m3", stable, 0);
        pulse(1100, 250, 1100);
        expect_meas("pitch_1100_m4", 1100, 250, 3, 1);

        // Asynchronous reset mid-period while stable
        repeat (100) step(1'b0);
        rst = 1'b1;
        #1;
        expect_reset("async_rst");
        sig_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n0 = n_valid;
        pulse(1000, 250, 0);
        check("post_rst_first", n_valid, n0);
        check("post_rst_silent", silent, 1);
        pulse(1000, 250, 1000);
        check("post_rst_second", n_valid, n0 + 1);
        expect_meas("post_rst", 1000, 250, 3, 0);

        check("exp_q_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tone_period_meter.md
Name: tone_period_meter

Overview:
Receive-side counterpart to the piezo tone generators. Measures a pulse-width tone waveform on a single input:
- period (rise-to-rise) and high time, in clk cycles
- duty class
- silence (no edges) and pitch stability
Used for on-board self-test of the piezo path and as a tone decoder for simulated external sound sources. It sits between a pin or sound-bus tap and the status/display logic.

Parameters:
- PW, 21: width of period/high counters and outputs; must hold TIMEOUT.
- TIMEOUT, 2_000_000: cycles with no accepted rise before declaring silence (40 ms at 50 MHz).
- MIN_PERIOD, 1000: rises closer than this to the previous accepted rise are glitches and are discarded.
- STABLE_N, 4: consecutive in-tolerance measurements required for stable.
- TOL_SHIFT, 6: tolerance is prev_period >> TOL_SHIFT.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- sig_in  in  1  tone waveform, asynchronous to clk
- period_out  out  PW  last accepted period in cycles
- high_out  out  PW  high cycles within that period
- duty_class  out  3  0 none, 1 ≈6.25%, 2 ≈12.5%, 3 ≈25%, 4 other
- valid  out  1  one-cycle pulse when the outputs above update
- silent  out  1  no tone present
- stable  out  1  pitch steady

Behaviour:
- Reset values (async, any time, including mid-measurement): period_out=0, high_out=0, duty_class=0, valid=0, silent=1, stable=0.
  - Internally: FSM=IDLE, cnt=0, hcnt=0, match_cnt=0, prev_period=0, sync regs=0.
- Input conditioning and edge detection:
  - sig_in passes through 2-FF synchroniser → sig_s; prev_s is sig_s delayed 1 cycle.
  - rise = sig_s & ~prev_s.
- Counters:
  - On any accepted rise: cnt<=1 and hcnt<=1.
  - Otherwise: cnt<=cnt+1, saturating at TIMEOUT.
  - Otherwise, while sig_s=1: hcnt<=hcnt+1, saturating at TIMEOUT.
  - Glitch rises do not touch the counters.
- FSM states: IDLE (no reference edge), MEASURE (reference edge held).
  - IDLE + rise → MEASURE. Counters restart; no valid.
  - MEASURE + rise with cnt < MIN_PERIOD → glitch. Ignored entirely; high cycles of the glitch remain in hcnt.
  - MEASURE + rise with cnt >= MIN_PERIOD → accept:
    - period_out<=cnt, high_out<=hcnt, duty_class per rule below.
    - valid<=1 for exactly one cycle; silent<=0.
    - Stability update; prev_period<=cnt. Stay in MEASURE.
  - MEASURE, no rise, cnt==TIMEOUT → IDLE:
    - silent<=1, stable<=0, match_cnt<=0.
    - period_out<=0, high_out<=0, duty_class<=0.
  - A rise in the same cycle as cnt==TIMEOUT takes priority and is accepted as period=TIMEOUT.
- Latency: a sig_in rise meeting setup before clk edge k gives sig_s=1 after edge k+1. valid and the outputs update at edge k+2.
- Duty class, computed from the accepted cnt/hcnt (P, H) and registered with period_out. Uses PW+5-bit intermediates; constant multiplies are shift/add only, no divider.
  - H*32 < P*3 → 1
  - else H*32 < P*6 → 2
  - else H*32 < P*12 → 3
  - else → 4
  - H=0 (flat-low period) yields class 1.
- Stability, on each accepted measurement:
  - First accept after IDLE: match_cnt<=1.
  - Else if |P − prev_period| <= prev_period>>TOL_SHIFT: match_cnt<=min(match_cnt+1, STABLE_N).
  - Else: match_cnt<=1.
  - stable = (match_cnt==STABLE_N), registered; updates with valid.
- Outputs hold between valid pulses. valid never asserts in IDLE or on the first rise after IDLE.

Test Plan:
1. Square wave, period 1000, high 250, 6 rises:
   - valid pulses on rises 2–6 with period_out=1000, high_out=250, duty_class=3.
   - silent falls at the first valid; stable=1 from the 4th valid.
2. Duty sweep at period 1000, high 62/125/500:
   - duty_class = 1 / 2 / 4 respectively.
   - period 1000, high 0 → class 1.
3. Glitch rejection: accepted rise, a 5-cycle pulse 300 cycles later, next rise at 1000:
   - no valid at 300.
   - valid with period_out=1000, high_out = first high + 5.
4. Silence: stable tone, then input held low:
   - exactly TIMEOUT cycles after the last rise, silent=1, stable=0, period_out=0, duty_class=0.
   - next rise produces no valid; the following rise does.
5. Pitch change after stable at 1000:
   - 1010 (diff 10 <= 15) keeps stable=1.
   - 1100 drops stable to 0; stable=1 again after 3 more valid periods of 1100.
6. rst asserted mid-period while stable:
   - all outputs at reset values immediately (async).
   - after release, the first rise gives no valid; the second gives correct period_out.
